// File: rtl/demux_pkg.sv
// Shared constants, lane state type and select decode for the demux_router slice.
package demux_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;
   localparam int CNT_W     = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } lane_state_t;

   // One-hot lane decode of a destination select.
   function automatic logic [NUM_LANES-1:0] sel_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_LANES-1:0] onehot;
      onehot      = '0;
      onehot[sel] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One output lane of demux_router: a one-entry valid/ready slot.
// With DEMUX_CNT_EN defined the lane also counts its drains (8-bit, wrapping).
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt
`endif
);

   lane_state_t      state_reg;
   logic [WIDTH-1:0] data_reg;
   logic             drain;

   assign drain = (state_reg == FULL) & ready;
   assign valid = (state_reg == FULL);
   assign data  = data_reg;

   // A load wins over a same-cycle drain so the slot stays FULL with the new word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= EMPTY;
         data_reg  <= '0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (load) begin
                  state_reg <= FULL;
                  data_reg  <= load_data;
               end
            end
            FULL: begin
               if (load) begin
                  data_reg <= load_data;
               end else if (drain) begin
                  state_reg <= EMPTY;
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (drain) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign cnt = cnt_reg;
`endif

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-4 stream demultiplexer with per-lane one-entry slots.
// Optional per-lane drain counters on out_cnt when DEMUX_CNT_EN is defined.
module demux_router
   import demux_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [SEL_W-1:0]           in_sel,
   output logic [NUM_LANES-1:0]       out_valid,
   input  logic [NUM_LANES-1:0]       out_ready,
   output logic [NUM_LANES*WIDTH-1:0] out_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [NUM_LANES*CNT_W-1:0] out_cnt
`endif
);

   logic [NUM_LANES-1:0] sel_onehot;
   logic [NUM_LANES-1:0] load;
   logic                 accept;

   // Ready depends only on the addressed lane, never on in_valid.
   assign in_ready   = !out_valid[in_sel] | out_ready[in_sel];
   assign accept     = in_valid & in_ready;
   assign sel_onehot = sel_decode(in_sel);

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign load[gi] = accept & sel_onehot[gi];

         demux_slot #(
            .WIDTH (WIDTH)
         ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[gi]),
            .load_data (in_data),
            .ready     (out_ready[gi]),
            .valid     (out_valid[gi]),
            .data      (out_data[gi*WIDTH +: WIDTH])
`ifdef DEMUX_CNT_EN
            ,
            .cnt       (out_cnt[gi*CNT_W +: CNT_W])
`endif
         );
      end
   endgenerate

endmodule

// File: tb/tb_demux_router.sv
// Directed table-driven bench for demux_router, plus reset and counter sequences.
module tb_demux_router;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_data;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] out_data;
`ifdef DEMUX_CNT_EN
   logic [31:0] out_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   demux_router #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DEMUX_CNT_EN
      ,
      .out_cnt   (out_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  sel;
      logic [3:0]  d;
      logic [3:0]  ordy;
      logic        exp_ir;
      logic [3:0]  exp_ov;
      logic [15:0] exp_od;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   initial begin
      //            v     sel   d     ordy     ir    ov       od
      tbl[0]  = '{1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0100, 16'h0A00};
      tbl[1]  = '{1'b0, 2'd2, 4'h0, 4'b0000, 1'b0, 4'b0100, 16'h0A00};
      tbl[2]  = '{1'b0, 2'd1, 4'h0, 4'b0000, 1'b1, 4'b0100, 16'h0A00};
      tbl[3]  = '{1'b1, 2'd1, 4'h3, 4'b0000, 1'b1, 4'b0110, 16'h0A30};
      tbl[4]  = '{1'b1, 2'd1, 4'h5, 4'b0000, 1'b0, 4'b0110, 16'h0A30};
      tbl[5]  = '{1'b1, 2'd1, 4'h5, 4'b0000, 1'b0, 4'b0110, 16'h0A30};
      tbl[6]  = '{1'b1, 2'd1, 4'h5, 4'b0000, 1'b0, 4'b0110, 16'h0A30};
      tbl[7]  = '{1'b1, 2'd1, 4'h5, 4'b0010, 1'b1, 4'b0110, 16'h0A50};
      tbl[8]  = '{1'b0, 2'd0, 4'h0, 4'b0110, 1'b1, 4'b0000, 16'h0A50};
      tbl[9]  = '{1'b1, 2'd3, 4'h1, 4'b1000, 1'b1, 4'b1000, 16'h1A50};
      tbl[10] = '{1'b1, 2'd3, 4'h2, 4'b1000, 1'b1, 4'b1000, 16'h2A50};
      tbl[11] = '{1'b1, 2'd3, 4'h3, 4'b1000, 1'b1, 4'b1000, 16'h3A50};
      tbl[12] = '{1'b1, 2'd3, 4'h4, 4'b1000, 1'b1, 4'b1000, 16'h4A50};
      tbl[13] = '{1'b0, 2'd3, 4'h0, 4'b1000, 1'b1, 4'b0000, 16'h4A50};
      tbl[14] = '{1'b1, 2'd0, 4'h7, 4'b0000, 1'b1, 4'b0001, 16'h4A57};
      tbl[15] = '{1'b1, 2'd2, 4'h9, 4'b0001, 1'b1, 4'b0100, 16'h4957};
      tbl[16] = '{1'b0, 2'd0, 4'h0, 4'b1011, 1'b1, 4'b0100, 16'h4957};
      tbl[17] = '{1'b1, 2'd0, 4'hC, 4'b0000, 1'b1, 4'b0101, 16'h495C};
      tbl[18] = '{1'b1, 2'd3, 4'hE, 4'b0100, 1'b1, 4'b1001, 16'hE95C};

      // Reset with a word offered: nothing may load.
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 2'd2;
      in_data   = 4'hF;
      out_ready = 4'b0000;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset out_data", 32'(out_data), 32'h0);
      chk("reset in_ready", 32'(in_ready), 32'h1);
`ifdef DEMUX_CNT_EN
      chk("reset out_cnt", out_cnt, 32'h0);
`endif
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_valid  = tbl[i].v;
         in_sel    = tbl[i].sel;
         in_data   = tbl[i].d;
         out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
         chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tbl[i].exp_od));
      end

      // Lanes 0 and 3 are FULL: asynchronous reset must clear them before any edge.
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      #2;
      reset = 1'b1;
      #1;
      chk("async reset out_valid", 32'(out_valid), 32'h0);
      chk("async reset out_data", 32'(out_data), 32'h0);
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 4'h6;
      #1;
      chk("async reset in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("reset held no load", 32'(out_valid), 32'h0);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;

`ifdef DEMUX_CNT_EN
      // 257 drains on lane 0: 256 load+drain cycles, then one plain drain.
      @(negedge clk);
      chk("cnt after reset", out_cnt, 32'h0);
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 4'h3;
      out_ready = 4'b0001;
      repeat (257) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("cnt 257 drains", out_cnt, 32'h0000_0001);
      chk("lane0 empty after drains", 32'(out_valid), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_router.md
# demux_router

Registered 1-to-4 stream demultiplexer, the distribution side of the existing registered 4:1 output mux. A single valid/ready input stream carries a 2-bit destination select. Each accepted word is steered into one of four independent one-entry output slots, and each slot has its own valid/ready handshake. Sits between a shared producer and four per-lane consumers.

## Interface
Parameters:
- WIDTH, 4: data width of the input and of each output lane.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when high together with in_valid.
- in_data  input  WIDTH  input payload.
- in_sel  input  2  destination lane: 00→0, 01→1, 10→2, 11→3.
- out_valid  output  4  per-lane slot full.
- out_ready  input  4  per-lane consumer ready.
- out_data  output  4*WIDTH  lane n occupies bits [n*WIDTH +: WIDTH].
- out_cnt  output  32  per-lane transfer counter, lane n at bits [n*8 +: 8]. Present only with DEMUX_CNT_EN.

## Operation
- Each lane is a 2-state machine.
  - EMPTY: out_valid[n]=0.
  - FULL: out_valid[n]=1, out_data lane n held stable.
- in_ready = !out_valid[in_sel] | out_ready[in_sel]. It is combinational from in_sel, out_valid and out_ready only; it never depends on in_valid.
- Accept = in_valid & in_ready. On accept, lane in_sel loads in_data and goes FULL at the next edge.
- Drain = out_valid[n] & out_ready[n]. On drain with no load to that lane, the lane goes EMPTY. out_data keeps its last value and is not cleared.
- Drain and load to the same lane in the same cycle: the lane stays FULL with the new data. This gives full throughput, one word per cycle per lane.
- A load to lane n and drains on other lanes proceed independently in the same cycle.
- The producer must hold in_data and in_sel stable while in_valid=1 and in_ready=0. Changing in_sel under backpressure is a protocol violation; the behaviour is then whatever the new in_sel yields.
- A blocked lane does not stall words addressed to other lanes once in_sel changes after a transfer completes. There is no head-of-line state inside the block.

## Timing
- Latency: one cycle from the accept edge to out_valid high on the target lane.
- Reset (asynchronous assert, synchronous release on the first clk edge after deassert):
  - out_valid=0000.
  - out_data all zero.
  - out_cnt all zero.
  - Consequence: in_ready=1 during reset, but no accept takes effect while reset is high.
- Reset asserted mid-transfer: all FULL slots are discarded immediately, with no drain.
- out_ready is ignored on EMPTY lanes.

## Configuration
- DEMUX_CNT_EN defined:
  - out_cnt is present, one 8-bit counter per lane.
  - A counter increments on each drain of its lane and wraps 255→0.
  - Counters are cleared by reset only.
- DEMUX_CNT_EN undefined:
  - The out_cnt port and the counter logic are absent.
  - All other behaviour is identical.

## Structure
- Package demux_pkg holds:
  - NUM_LANES=4, SEL_W=2, CNT_W=8.
  - typedef lane_state_t enum {EMPTY, FULL}.
- Sub-module demux_slot is one lane.
  - Ports: clk, reset, load, load_data, ready, valid, data, plus cnt under DEMUX_CNT_EN.
  - The top instantiates four of them and generates in_ready and the per-lane load decode.

## Test plan
- Reset release, then in_sel=10, in_data=A, in_valid for 1 cycle, all out_ready=0 → next cycle out_valid=0100, lane 2 data=A, in_ready=0 for in_sel=10 and 1 for other selects.
- Lane 1 FULL, out_ready[1]=0, in_sel=01 held with data=5 for 3 cycles → in_ready=0 throughout and lane 1 data unchanged. Then out_ready[1]=1 → accept occurs that cycle and lane 1 holds 5 next cycle.
- Streaming lane 3 with out_ready[3]=1, data 1,2,3,4 on consecutive cycles → out_valid[3]=1 for 4 consecutive cycles, outputs 1,2,3,4 one cycle late, no bubbles.
- Simultaneous: drain lane 0 and load lane 2 in the same cycle → out_valid goes 0001→0100.
- Reset asserted while lanes 0 and 3 are FULL → out_valid=0000 and data zero immediately, before the next clk edge.
- With DEMUX_CNT_EN: 257 drains on lane 0 → out_cnt lane 0 = 1, other lanes 0.
